countdown_ctrl: RTL and testbench

Sequencer for the centre-screen digit sprite: on a start request it runs a 3-2-1 countdown, one digit per programmable step, and drives the sprite's digit select and visibility. Display outputs change only on frame boundaries, so a digit never switches mid-frame. Sits between game-state logic (start/abort/pause) and the VGA pixel path that renders digits 1–3 in the centre box.

---
 rtl/countdown_ctrl_pkg.sv | 21 ++
 rtl/countdown_ctrl_step.sv | 38 +++
 rtl/countdown_ctrl.sv | 111 +++++++++++
 tb/tb_countdown_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the centre-screen countdown sequencer:
// FSM state encoding, digit constants and default timing.
package countdown_ctrl_pkg;

    localparam int unsigned PIXEL_CLK_HZ       = 25_000_000;
    localparam int unsigned DEFAULT_STEP_TICKS = PIXEL_CLK_HZ;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] DIGIT_NONE  = 2'd0;
    localparam logic [1:0] DIGIT_FIRST = 2'd3;
    localparam logic [1:0] DIGIT_LAST  = 2'd1;

    function automatic logic [1:0] next_digit(input logic [1:0] d);
        return d - 2'd1;
    endfunction

endpackage

// File: rtl/countdown_ctrl_step.sv
// Step timer: counts enabled cycles and pulses tc on the last cycle of each step.
module step_timer
    import countdown_ctrl_pkg::*;
#(
    parameter int unsigned STEP_TICKS = DEFAULT_STEP_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int unsigned     CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tc    = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// 3-2-1 countdown sequencer for the digit sprite; display outputs are
// latched only on frame_start so a digit never switches mid-frame.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int unsigned STEP_TICKS = DEFAULT_STEP_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    input  logic       frame_start,
    output logic [1:0] num,
    output logic       show,
    output logic       busy,
    output logic       go
);

    state_e     state_q, state_d;
    logic [1:0] digit_q, digit_d;
    logic [1:0] num_q,   num_d;
    logic       show_q,  show_d;
    logic       busy_q,  busy_d;
    logic       go_q,    go_d;

    logic start_ok;
    logic timer_en;
    logic timer_clr;
    logic tc;

    assign start_ok  = (state_q == ST_IDLE) && start && !abort;
    assign timer_en  = (state_q == ST_RUN) && !pause && !abort;
    // Clearing on abort as well as on start guarantees a restart gets a full first step.
    assign timer_clr = abort || start_ok;

    step_timer #(
        .STEP_TICKS (STEP_TICKS)
    ) u_step_timer (
        .clk (clk),
        .rst (rst),
        .en  (timer_en),
        .clr (timer_clr),
        .tc  (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            digit_q <= DIGIT_NONE;
            num_q   <= DIGIT_NONE;
            show_q  <= 1'b0;
            busy_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            num_q   <= num_d;
            show_q  <= show_d;
            busy_q  <= busy_d;
            go_q    <= go_d;
        end
    end

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                    digit_d = DIGIT_FIRST;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    digit_d = DIGIT_NONE;
                end else if (tc) begin
                    if (digit_q == DIGIT_LAST) begin
                        state_d = ST_IDLE;
                        digit_d = DIGIT_NONE;
                    end else begin
                        digit_d = next_digit(digit_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                digit_d = DIGIT_NONE;
            end
        endcase
    end

    always_comb begin
        busy_d = (state_d == ST_RUN);
        go_d   = (state_q == ST_RUN) && !abort && tc && (digit_q == DIGIT_LAST);
        num_d  = num_q;
        show_d = show_q;
        if (frame_start) begin
            num_d  = (state_q == ST_RUN) ? digit_q : DIGIT_NONE;
            show_d = (state_q == ST_RUN);
        end
    end

    assign num  = num_q;
    assign show = show_q;
    assign busy = busy_q;
    assign go   = go_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: directed scenarios plus random
// traffic, compared every cycle against an elapsed-time reference model.
module tb_countdown_ctrl;

    localparam int unsigned STEP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       pause = 1'b0;
    logic       frame_start = 1'b0;
    logic [1:0] num;
    logic       show;
    logic       busy;
    logic       go;

    int checks = 0;
    int errors = 0;

    // Reference model: running flag plus count of unpaused cycles since start.
    bit         m_run = 0;
    int         m_el = 0;
    logic [1:0] m_num = 2'd0;
    logic       m_show = 1'b0;
    logic       m_go = 1'b0;

    int cyc_n = 0;
    int go_at = -1;
    int go_count = 0;

    countdown_ctrl #(
        .STEP_TICKS (STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pause       (pause),
        .frame_start (frame_start),
        .num         (num),
        .show        (show),
        .busy        (busy),
        .go          (go)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] m_digit();
        return m_run ? 2'(3 - m_el / int'(STEP)) : 2'd0;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc_n + 1, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit a, input bit p, input bit f);
        if (r) begin
            m_run = 0; m_el = 0; m_go = 0; m_num = 2'd0; m_show = 0;
        end else begin
            if (f) begin
                m_num  = m_digit();
                m_show = m_run;
            end
            m_go = 0;
            if (m_run) begin
                if (a) begin
                    m_run = 0; m_el = 0;
                end else if (!p) begin
                    m_el++;
                    if (m_el == 3 * int'(STEP)) begin
                        m_run = 0; m_el = 0; m_go = 1;
                    end
                end
            end else if (s && !a) begin
                m_run = 1; m_el = 0;
            end
        end
    endtask

    // One clock cycle: apply inputs, advance model, compare after the edge.
    task automatic cyc(input bit r, input bit s, input bit a, input bit p, input bit f);
        rst = r; start = s; abort = a; pause = p; frame_start = f;
        model_step(r, s, a, p, f);
        @(posedge clk);
        #1;
        check("num",  int'(num),  int'(m_num));
        check("show", int'(show), int'(m_show));
        check("busy", int'(busy), int'(m_run));
        check("go",   int'(go),   int'(m_go));
        if (go) begin
            go_at = cyc_n + 1;
            go_count++;
        end
        cyc_n++;
    endtask

    task automatic begin_scenario();
        cyc(1, 0, 0, 0, 0);
        cyc_n = 0;
        go_at = -1;
        go_count = 0;
    endtask

    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);

        // Nominal run, frame_start every cycle
        begin_scenario();
        for (int c = 0; c < 16; c++) cyc(0, c == 0, 0, 0, 1);
        check("nominal_go_cycle", go_at, 13);
        check("nominal_go_count", go_count, 1);

        // Frame-gated display: strobe every 5 cycles starting at cycle 3
        begin_scenario();
        for (int c = 0; c < 20; c++) cyc(0, c == 0, 0, 0, (c >= 3) && ((c - 3) % 5 == 0));
        check("gated_go_cycle", go_at, 13);

        // Pause during cycles 6..8
        begin_scenario();
        for (int c = 0; c < 19; c++) cyc(0, c == 0, 0, (c >= 6) && (c <= 8), 1);
        check("pause_go_cycle", go_at, 16);

        // Abort in cycle 7, restart in cycle 9
        begin_scenario();
        for (int c = 0; c < 9; c++) cyc(0, c == 0, c == 7, 0, 1);
        check("abort_no_go", go_count, 0);
        for (int c = 9; c < 25; c++) cyc(0, c == 9, 0, 0, 1);
        check("restart_go_cycle", go_at, 22);

        // start+abort together in IDLE stays idle
        begin_scenario();
        cyc(0, 1, 1, 0, 1);
        check("start_abort_idle", int'(busy), 0);
        for (int c = 1; c < 6; c++) cyc(0, 0, 0, 0, 1);

        // start during a run is ignored; start in go cycle begins a new run
        begin_scenario();
        for (int c = 0; c < 18; c++) cyc(0, (c == 0) || (c == 5) || (c == 13), 0, 0, 1);
        check("ignored_start_go_cycle", go_at, 13);
        check("restart_in_go_busy", int'(busy), 1);
        check("restart_in_go_num", int'(num), 3);

        // Reset mid-run
        begin_scenario();
        for (int c = 0; c < 20; c++) cyc(c == 6, c == 0, 0, 0, 1);
        check("rst_mid_no_go", go_count, 0);

        // Randomised traffic
        begin_scenario();
        for (int c = 0; c < 600; c++) begin
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
